rob_unit: RTL and testbench

ROB_UNIT -- requirements
Module: rob_unit

---
 rtl/rob_unit.sv | 156 +++++++++++++++
 tb/tb_rob_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_unit.sv
// Reorder buffer: in-order issue into a circular buffer, out-of-order writeback,
// in-order commit, and a full flush when a committing branch was mispredicted.
module rob_unit #(
  parameter int ROB_BIT = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  // issue
  input  logic               issue_valid,
  input  logic [1:0]         issue_type,
  input  logic [4:0]         issue_rd,
  input  logic [31:0]        issue_pc,
  input  logic               issue_pred_jump,
  output logic               rob_full,
  output logic               rob_empty,
  output logic [ROB_BIT-1:0] issue_rob_entry,
  // writeback
  input  logic               wb_valid,
  input  logic [ROB_BIT-1:0] wb_rob_entry,
  input  logic [31:0]        wb_value,
  input  logic               wb_jump,
  input  logic [31:0]        wb_redirect_pc,
  // commit
  output logic               rob_commit,
  output logic [4:0]         commit_reg_id,
  output logic [31:0]        commit_reg_data,
  output logic [ROB_BIT-1:0] commit_rob_entry,
  output logic               store_commit,
  // flush
  output logic               rob_clear_up,
  output logic [31:0]        clear_pc,
  // operand lookup
  input  logic [ROB_BIT-1:0] get_rob_entry1,
  output logic               ready1,
  output logic [31:0]        value1,
  input  logic [ROB_BIT-1:0] get_rob_entry2,
  output logic               ready2,
  output logic [31:0]        value2
);

  localparam int unsigned DEPTH = 1 << ROB_BIT;
  localparam logic [ROB_BIT:0] FULL_COUNT = {1'b1, {ROB_BIT{1'b0}}};

  typedef enum logic [1:0] {
    ROB_REG   = 2'd0,
    ROB_BR    = 2'd1,
    ROB_STORE = 2'd2
  } rob_type_e;

  logic [DEPTH-1:0]   busy;
  logic [DEPTH-1:0]   ready;
  logic [1:0]         kind_q      [DEPTH];
  logic [4:0]         rd_q        [DEPTH];
  logic [31:0]        pc_q        [DEPTH];
  logic               pred_q      [DEPTH];
  logic [31:0]        value_q     [DEPTH];
  logic               jump_q      [DEPTH];
  logic [31:0]        redirect_q  [DEPTH];

  logic [ROB_BIT-1:0] head, tail;
  logic [ROB_BIT:0]   count;

  logic do_issue, do_wb, do_commit, mispredict;

  assign rob_full        = (count == FULL_COUNT);
  assign rob_empty       = (count == '0);
  assign issue_rob_entry = tail;

  always_comb begin
    do_issue   = issue_valid && !rob_full && !rob_clear_up;
    do_wb      = wb_valid && busy[wb_rob_entry] && !rob_clear_up;
    do_commit  = busy[head] && ready[head] && !rob_clear_up;
    mispredict = do_commit && (kind_q[head] == ROB_BR) && (jump_q[head] != pred_q[head]);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      busy             <= '0;
      ready            <= '0;
      rob_commit       <= 1'b0;
      store_commit     <= 1'b0;
      rob_clear_up     <= 1'b0;
      commit_reg_id    <= '0;
      commit_reg_data  <= '0;
      commit_rob_entry <= '0;
      clear_pc         <= '0;
    end else if (rdy_in) begin
      rob_commit   <= 1'b0;
      store_commit <= 1'b0;
      rob_clear_up <= 1'b0;

      if (do_issue) begin
        busy[tail]   <= 1'b1;
        ready[tail]  <= 1'b0;
        kind_q[tail] <= issue_type;
        rd_q[tail]   <= issue_rd;
        pc_q[tail]   <= issue_pc;
        pred_q[tail] <= issue_pred_jump;
        tail         <= tail + ROB_BIT'(1);
      end

      if (do_wb) begin
        ready[wb_rob_entry]      <= 1'b1;
        value_q[wb_rob_entry]    <= wb_value;
        jump_q[wb_rob_entry]     <= wb_jump;
        redirect_q[wb_rob_entry] <= wb_redirect_pc;
      end

      if (do_commit) begin
        busy[head]       <= 1'b0;
        head             <= head + ROB_BIT'(1);
        rob_commit       <= (kind_q[head] != ROB_STORE);
        store_commit     <= (kind_q[head] == ROB_STORE);
        commit_reg_id    <= rd_q[head];
        commit_reg_data  <= value_q[head];
        commit_rob_entry <= head;
      end

      if (do_issue && !do_commit)
        count <= count + (ROB_BIT+1)'(1);
      else if (do_commit && !do_issue)
        count <= count - (ROB_BIT+1)'(1);

      // Flush is last so it overrides any issue/writeback landing on the same edge.
      if (mispredict) begin
        rob_clear_up <= 1'b1;
        clear_pc     <= redirect_q[head];
        busy         <= '0;
        ready        <= '0;
        head         <= '0;
        tail         <= '0;
        count        <= '0;
      end
    end
  end

  always_comb begin
    ready1 = ready[get_rob_entry1];
    value1 = value_q[get_rob_entry1];
    if (wb_valid && (wb_rob_entry == get_rob_entry1)) begin
      ready1 = 1'b1;
      value1 = wb_value;
    end
    ready2 = ready[get_rob_entry2];
    value2 = value_q[get_rob_entry2];
    if (wb_valid && (wb_rob_entry == get_rob_entry2)) begin
      ready2 = 1'b1;
      value2 = wb_value;
    end
  end

endmodule

// File: tb/tb_rob_unit.sv
// Directed bench for rob_unit: expected commits are queued as stimulus is driven
// and popped whenever the DUT raises a commit pulse.
module tb_rob_unit;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_valid;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic        issue_pred_jump;
  logic        rob_full, rob_empty;
  logic [2:0]  issue_rob_entry;
  logic        wb_valid;
  logic [2:0]  wb_rob_entry;
  logic [31:0] wb_value;
  logic        wb_jump;
  logic [31:0] wb_redirect_pc;
  logic        rob_commit;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_reg_data;
  logic [2:0]  commit_rob_entry;
  logic        store_commit;
  logic        rob_clear_up;
  logic [31:0] clear_pc;
  logic [2:0]  get_rob_entry1, get_rob_entry2;
  logic        ready1, ready2;
  logic [31:0] value1, value2;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  entry;
    logic        store;
  } exp_t;

  exp_t exp_q[$];

  rob_unit #(.ROB_BIT(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_jump(issue_pred_jump),
    .rob_full(rob_full), .rob_empty(rob_empty), .issue_rob_entry(issue_rob_entry),
    .wb_valid(wb_valid), .wb_rob_entry(wb_rob_entry), .wb_value(wb_value),
    .wb_jump(wb_jump), .wb_redirect_pc(wb_redirect_pc),
    .rob_commit(rob_commit), .commit_reg_id(commit_reg_id),
    .commit_reg_data(commit_reg_data), .commit_rob_entry(commit_rob_entry),
    .store_commit(store_commit), .rob_clear_up(rob_clear_up), .clear_pc(clear_pc),
    .get_rob_entry1(get_rob_entry1), .ready1(ready1), .value1(value1),
    .get_rob_entry2(get_rob_entry2), .ready2(ready2), .value2(value2)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit later and any commit pulse
  // produced by an active (rdy, not reset) edge is matched against the queue.
  task automatic tick();
    logic active;
    exp_t e;
    active = rdy_in && !rst_in;
    @(posedge clk_in);
    #1;
    if (active && (rob_commit || store_commit)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", {31'd0, rob_commit | store_commit}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("commit_reg_id", {27'd0, commit_reg_id}, {27'd0, e.rd});
        check("commit_reg_data", commit_reg_data, e.data);
        check("commit_rob_entry", {29'd0, commit_rob_entry}, {29'd0, e.entry});
        check("store_commit", {31'd0, store_commit}, {31'd0, e.store});
        check("rob_commit", {31'd0, rob_commit}, {31'd0, ~e.store});
      end
    end
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic pred);
    issue_valid = 1'b1; issue_type = t; issue_rd = rd;
    issue_pc = {24'h0, 3'd0, rd} << 2; issue_pred_jump = pred;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic wb(input logic [2:0] ent, input logic [31:0] val,
                    input logic jmp, input logic [31:0] redir);
    wb_valid = 1'b1; wb_rob_entry = ent; wb_value = val;
    wb_jump = jmp; wb_redirect_pc = redir;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    issue_valid = 0; issue_type = 0; issue_rd = 0; issue_pc = 0; issue_pred_jump = 0;
    wb_valid = 0; wb_rob_entry = 0; wb_value = 0; wb_jump = 0; wb_redirect_pc = 0;
    get_rob_entry1 = 0; get_rob_entry2 = 0;
    tick(); tick();
    rst_in = 1'b0;

    // reset state
    check("rst_empty", {31'd0, rob_empty}, 32'd1);
    check("rst_full", {31'd0, rob_full}, 32'd0);
    check("rst_tail", {29'd0, issue_rob_entry}, 32'd0);
    check("rst_commit", {30'd0, rob_commit, store_commit}, 32'd0);
    check("rst_clear", {31'd0, rob_clear_up}, 32'd0);
    check("rst_clear_pc", clear_pc, 32'd0);

    // in-order commit despite out-of-order writeback
    issue(2'd0, 5'd5, 1'b0);
    issue(2'd0, 5'd6, 1'b0);
    check("order_tail", {29'd0, issue_rob_entry}, 32'd2);
    wb(3'd1, 32'h22, 1'b0, 32'h0);
    exp_q.push_back('{rd: 5'd5, data: 32'h11, entry: 3'd0, store: 1'b0});
    exp_q.push_back('{rd: 5'd6, data: 32'h22, entry: 3'd1, store: 1'b0});
    wb(3'd0, 32'h11, 1'b0, 32'h0);
    check("order_pending0", exp_q.size(), 32'd2);
    tick();
    check("order_pending1", exp_q.size(), 32'd1);
    tick();
    check("order_pending2", exp_q.size(), 32'd0);
    tick();
    check("order_idle", {31'd0, rob_commit}, 32'd0);
    check("order_empty", {31'd0, rob_empty}, 32'd1);

    // full and wrap-around
    pulse_reset();
    for (int i = 0; i < 8; i++) issue(2'd0, 5'(i + 1), 1'b0);
    check("full_flag", {31'd0, rob_full}, 32'd1);
    check("full_tail", {29'd0, issue_rob_entry}, 32'd0);
    issue(2'd0, 5'd31, 1'b0);
    check("full_9th_tail", {29'd0, issue_rob_entry}, 32'd0);
    check("full_9th_flag", {31'd0, rob_full}, 32'd1);
    wb(3'd0, 32'h100, 1'b0, 32'h0);
    exp_q.push_back('{rd: 5'd1, data: 32'h100, entry: 3'd0, store: 1'b0});
    issue(2'd0, 5'd30, 1'b0);
    check("full_commit_seen", exp_q.size(), 32'd0);
    check("full_after_commit", {31'd0, rob_full}, 32'd0);
    check("wrap_tail", {29'd0, issue_rob_entry}, 32'd0);
    issue(2'd0, 5'd20, 1'b0);
    check("wrap_tail_next", {29'd0, issue_rob_entry}, 32'd1);
    check("wrap_full", {31'd0, rob_full}, 32'd1);

    // writeback bypass on the lookup ports
    get_rob_entry1 = 3'd3; get_rob_entry2 = 3'd4;
    wb_valid = 1'b1; wb_rob_entry = 3'd3; wb_value = 32'hABCD;
    #1;
    check("bypass_ready1", {31'd0, ready1}, 32'd1);
    check("bypass_value1", value1, 32'hABCD);
    check("bypass_ready2", {31'd0, ready2}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    check("stored_ready1", {31'd0, ready1}, 32'd1);
    check("stored_value1", value1, 32'hABCD);

    // writeback to a non-busy entry is ignored
    pulse_reset();
    check("reset_full_empty", {31'd0, rob_empty}, 32'd1);
    wb(3'd5, 32'h55, 1'b0, 32'h0);
    get_rob_entry2 = 3'd5;
    #1;
    check("wb_nonbusy", {31'd0, ready2}, 32'd0);

    // branch mispredict flush
    issue(2'd0, 5'd7, 1'b0);
    issue(2'd1, 5'd0, 1'b0);
    issue(2'd0, 5'd8, 1'b0);
    exp_q.push_back('{rd: 5'd7, data: 32'h77, entry: 3'd0, store: 1'b0});
    exp_q.push_back('{rd: 5'd0, data: 32'h5, entry: 3'd1, store: 1'b0});
    wb(3'd0, 32'h77, 1'b0, 32'h0);
    wb(3'd1, 32'h5, 1'b1, 32'h1000);
    wb(3'd2, 32'h88, 1'b0, 32'h0);
    check("mis_commits", exp_q.size(), 32'd0);
    check("mis_clear", {31'd0, rob_clear_up}, 32'd1);
    check("mis_clear_pc", clear_pc, 32'h1000);
    issue(2'd0, 5'd12, 1'b0);
    check("mis_clear_off", {31'd0, rob_clear_up}, 32'd0);
    check("mis_empty", {31'd0, rob_empty}, 32'd1);
    check("mis_tail", {29'd0, issue_rob_entry}, 32'd0);

    // store commit
    issue(2'd2, 5'd3, 1'b0);
    wb(3'd0, 32'h99, 1'b0, 32'h0);
    exp_q.push_back('{rd: 5'd3, data: 32'h99, entry: 3'd0, store: 1'b1});
    tick();
    check("store_seen", exp_q.size(), 32'd0);

    // stall holds the commit pulse
    issue(2'd0, 5'd9, 1'b0);
    wb(3'd1, 32'h123, 1'b0, 32'h0);
    exp_q.push_back('{rd: 5'd9, data: 32'h123, entry: 3'd1, store: 1'b0});
    tick();
    check("stall_pre", exp_q.size(), 32'd0);
    rdy_in = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd10; issue_type = 2'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_hold", {31'd0, rob_commit}, 32'd1);
      check("stall_id", {27'd0, commit_reg_id}, 32'd9);
      check("stall_tail", {29'd0, issue_rob_entry}, 32'd2);
    end
    issue_valid = 1'b0;
    rdy_in = 1'b1;
    tick();
    check("stall_release", {31'd0, rob_commit}, 32'd0);
    check("stall_empty", {31'd0, rob_empty}, 32'd1);

    // reset with three in-flight entries, one about to commit
    issue(2'd0, 5'd1, 1'b0);
    issue(2'd0, 5'd2, 1'b0);
    issue(2'd0, 5'd3, 1'b0);
    wb(3'd2, 32'hDEAD, 1'b0, 32'h0);
    rdy_in = 1'b0;
    pulse_reset();
    rdy_in = 1'b1;
    check("rst3_commit", {30'd0, rob_commit, store_commit}, 32'd0);
    check("rst3_empty", {31'd0, rob_empty}, 32'd1);
    check("rst3_tail", {29'd0, issue_rob_entry}, 32'd0);
    check("rst3_data", commit_reg_data, 32'd0);
    tick();
    check("rst3_quiet", {31'd0, rob_commit}, 32'd0);
    check("final_queue", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
